// File: rtl/batam_loader_pkg.sv
// Shared types and constants for the bat_amateur program loader.
package batam_loader_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_SYNC,
      S_LEN_HI,
      S_LEN_LO,
      S_DATA_HI,
      S_DATA_LO,
      S_WRITE,
      S_CSUM,
      S_RELEASE,
      S_DONE,
      S_ERROR
   } state_e;

   localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

   // Level on RAM_RW that selects a write cycle on the core RAM.
   localparam logic RAM_RW_WRITE = 1'b1;

endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle counter: counts enabled cycles since the last clear and flags
// expiry once LIMIT idle cycles have elapsed.
module loader_timeout #(
   parameter int LIMIT = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          at_limit;

   assign at_limit = (cnt_q >= CW'(LIMIT - 1));
   assign expired  = en & at_limit;

   // Next count: clear wins, otherwise count enabled cycles and saturate.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && !at_limit) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/prog_loader.sv
// Framed serial program loader: hunts for sync, reads a word count, writes
// big-endian words into core RAM while the core is halted, verifies an XOR
// checksum and then boots the core with a reset pulse.
module prog_loader
   import batam_loader_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR  = 16'h0000,
   parameter logic [7:0]  SYNC_BYTE  = DEF_SYNC_BYTE,
   parameter int          RST_CYCLES = 4,
   parameter int          TIMEOUT    = 100000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        START,
   input  logic [7:0]  RX_DATA,
   input  logic        RX_VALID,
   output logic        RX_READY,
   output logic [15:0] ADDRESS,
   output logic [15:0] DATA_OUT,
   output logic        DATA_OE,
   output logic        RAM_EN,
   output logic        RAM_RW,
   output logic        HALT,
   output logic        CORE_RST,
   output logic        BUSY,
   output logic        DONE,
   output logic        ERR
);

   localparam int RW = $clog2(RST_CYCLES + 1);

   state_e          state_q, state_d;
   logic [15:0]     len_q, len_d;
   logic [15:0]     idx_q, idx_d;
   logic [7:0]      hi_q, hi_d;
   logic [15:0]     word_q, word_d;
   logic [7:0]      csum_q, csum_d;
   logic [RW-1:0]   rel_q, rel_d;

   logic            rx_ready_q, rx_ready_d;
   logic [15:0]     address_q, address_d;
   logic [15:0]     data_out_q, data_out_d;
   logic            data_oe_q, data_oe_d;
   logic            ram_en_q, ram_en_d;
   logic            ram_rw_q, ram_rw_d;
   logic            halt_q, halt_d;
   logic            core_rst_q, core_rst_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            err_q, err_d;

   logic            fire;
   logic            tmo_en, tmo_clr, tmo_exp;

   // RX_READY is a registered decode of the current state, so it gates the
   // handshake directly.
   assign fire = RX_VALID & rx_ready_q;

   // Timeout runs while waiting for frame bytes; WRITE freezes it, and every
   // accepted byte or any state outside the frame body restarts it.
   assign tmo_en  = (state_q == S_LEN_HI)  || (state_q == S_LEN_LO) ||
                    (state_q == S_DATA_HI) || (state_q == S_DATA_LO) ||
                    (state_q == S_CSUM);
   assign tmo_clr = fire || !(tmo_en || (state_q == S_WRITE));

   loader_timeout #(.LIMIT(TIMEOUT)) u_timeout (
      .clk     (CLK),
      .rst     (RST),
      .clr     (tmo_clr),
      .en      (tmo_en),
      .expired (tmo_exp)
   );

   // Next-state, datapath updates, and next output values decoded from the
   // next state so every output is a flop that tracks the current state.
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      idx_d      = idx_q;
      hi_d       = hi_q;
      word_d     = word_q;
      csum_d     = csum_q;
      rel_d      = rel_q;

      case (state_q)
         S_IDLE: begin
            if (START) state_d = S_SYNC;
         end
         S_SYNC: begin
            if (fire && (RX_DATA == SYNC_BYTE)) begin
               state_d = S_LEN_HI;
               csum_d  = '0;
               idx_d   = '0;
            end
         end
         S_LEN_HI: begin
            if (fire) begin
               len_d[15:8] = RX_DATA;
               csum_d      = csum_q ^ RX_DATA;
               state_d     = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (fire) begin
               len_d[7:0] = RX_DATA;
               csum_d     = csum_q ^ RX_DATA;
               state_d    = ({len_q[15:8], RX_DATA} == 16'd0) ? S_ERROR : S_DATA_HI;
            end
         end
         S_DATA_HI: begin
            if (fire) begin
               hi_d    = RX_DATA;
               csum_d  = csum_q ^ RX_DATA;
               state_d = S_DATA_LO;
            end
         end
         S_DATA_LO: begin
            if (fire) begin
               word_d  = {hi_q, RX_DATA};
               csum_d  = csum_q ^ RX_DATA;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            idx_d   = idx_q + 16'd1;
            state_d = ((idx_q + 16'd1) == len_q) ? S_CSUM : S_DATA_HI;
         end
         S_CSUM: begin
            if (fire) begin
               state_d = (RX_DATA == csum_q) ? S_RELEASE : S_ERROR;
               rel_d   = '0;
            end
         end
         S_RELEASE: begin
            if (rel_q == RW'(RST_CYCLES - 1)) state_d = S_DONE;
            else                              rel_d   = rel_q + RW'(1);
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         S_ERROR: begin
            if (START) state_d = S_SYNC;
         end
         default: state_d = S_IDLE;
      endcase

      // An accepted byte always beats an expiring idle count.
      if (tmo_exp && !fire) state_d = S_ERROR;

      rx_ready_d = (state_d == S_SYNC)    || (state_d == S_LEN_HI) ||
                   (state_d == S_LEN_LO)  || (state_d == S_DATA_HI) ||
                   (state_d == S_DATA_LO) || (state_d == S_CSUM);
      halt_d     = (state_d != S_IDLE) && (state_d != S_DONE);
      busy_d     = (state_d != S_IDLE) && (state_d != S_ERROR);
      core_rst_d = (state_d == S_RELEASE);
      done_d     = (state_d == S_DONE);
      err_d      = (state_d == S_ERROR);
      data_oe_d  = (state_d == S_WRITE);
      ram_en_d   = (state_d == S_WRITE);
      ram_rw_d   = (state_d == S_WRITE) ? RAM_RW_WRITE : ~RAM_RW_WRITE;
      address_d  = (state_d == S_WRITE) ? (BASE_ADDR + idx_d) : 16'd0;
      data_out_d = (state_d == S_WRITE) ? word_d : 16'd0;
   end

   // State, datapath and output registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= S_IDLE;
         len_q      <= '0;
         idx_q      <= '0;
         hi_q       <= '0;
         word_q     <= '0;
         csum_q     <= '0;
         rel_q      <= '0;
         rx_ready_q <= 1'b0;
         address_q  <= '0;
         data_out_q <= '0;
         data_oe_q  <= 1'b0;
         ram_en_q   <= 1'b0;
         ram_rw_q   <= 1'b0;
         halt_q     <= 1'b0;
         core_rst_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         idx_q      <= idx_d;
         hi_q       <= hi_d;
         word_q     <= word_d;
         csum_q     <= csum_d;
         rel_q      <= rel_d;
         rx_ready_q <= rx_ready_d;
         address_q  <= address_d;
         data_out_q <= data_out_d;
         data_oe_q  <= data_oe_d;
         ram_en_q   <= ram_en_d;
         ram_rw_q   <= ram_rw_d;
         halt_q     <= halt_d;
         core_rst_q <= core_rst_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign RX_READY = rx_ready_q;
   assign ADDRESS  = address_q;
   assign DATA_OUT = data_out_q;
   assign DATA_OE  = data_oe_q;
   assign RAM_EN   = ram_en_q;
   assign RAM_RW   = ram_rw_q;
   assign HALT     = halt_q;
   assign CORE_RST = core_rst_q;
   assign BUSY     = busy_q;
   assign DONE     = done_q;
   assign ERR      = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Two loaders (base 0x0000 and base 0xFFFF) driven by the same byte stream;
// expected RAM writes are queued per instance and checked as they appear.
module tb_prog_loader;

   localparam int RSTC = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start, rx_valid;
   logic [7:0]  rx_data;

   logic [1:0]       rx_ready, data_oe, ram_en, ram_rw, halt, core_rst, busy, done, err;
   logic [1:0][15:0] address, data_out;

   prog_loader #(.BASE_ADDR(16'h0000), .RST_CYCLES(RSTC), .TIMEOUT(50)) u_dut0 (
      .CLK(clk), .RST(rst), .START(start), .RX_DATA(rx_data), .RX_VALID(rx_valid),
      .RX_READY(rx_ready[0]), .ADDRESS(address[0]), .DATA_OUT(data_out[0]),
      .DATA_OE(data_oe[0]), .RAM_EN(ram_en[0]), .RAM_RW(ram_rw[0]), .HALT(halt[0]),
      .CORE_RST(core_rst[0]), .BUSY(busy[0]), .DONE(done[0]), .ERR(err[0])
   );

   prog_loader #(.BASE_ADDR(16'hFFFF), .RST_CYCLES(RSTC), .TIMEOUT(50)) u_dut1 (
      .CLK(clk), .RST(rst), .START(start), .RX_DATA(rx_data), .RX_VALID(rx_valid),
      .RX_READY(rx_ready[1]), .ADDRESS(address[1]), .DATA_OUT(data_out[1]),
      .DATA_OE(data_oe[1]), .RAM_EN(ram_en[1]), .RAM_RW(ram_rw[1]), .HALT(halt[1]),
      .CORE_RST(core_rst[1]), .BUSY(busy[1]), .DONE(done[1]), .ERR(err[1])
   );

   int checks = 0;
   int fails  = 0;

   logic [31:0] sb0[$];
   logic [31:0] sb1[$];
   logic [7:0]  txq[$];
   int          run[2], done_cnt[2], rst_cyc[2];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Expected write of word idx for both instances (16-bit address wrap).
   task automatic exp_write(input logic [15:0] idx, input logic [15:0] w);
      logic [15:0] a1;
      a1 = 16'hFFFF + idx;
      sb0.push_back({idx, w});
      sb1.push_back({a1, w});
   endtask

   // Write, core-reset and done monitor for both instances.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (ram_en[k]) begin
            logic [31:0] e;
            e = 'x;
            if (k == 0 && sb0.size() > 0) e = sb0.pop_front();
            if (k == 1 && sb1.size() > 0) e = sb1.pop_front();
            chk("wr_rx_ready", rx_ready[k], 1'b0);
            chk("wr_oe_rw", {data_oe[k], ram_rw[k]}, 2'b11);
            chk("wr_addr_data", {address[k], data_out[k]}, e);
         end
         if (core_rst[k]) begin
            run[k]++;
            rst_cyc[k]++;
         end else begin
            if (done[k]) begin
               done_cnt[k]++;
               chk("done_rst_run", run[k], RSTC);
               chk("done_halt", halt[k], 1'b0);
            end
            run[k] = 0;
         end
      end
   end

   task automatic pulse_start;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (rx_ready[0] !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) chk("rx_ready_wait", rx_ready[0], 1'b1);
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_q;
      while (txq.size() > 0) send_byte(txq.pop_front());
   endtask

   // Let the frame settle, then check outcome counters for both instances.
   task automatic end_frame(input string tag, input int e_done, input logic e_err,
                            input logic e_halt, input int e_rst);
      repeat (12) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk({tag, "_done"}, done_cnt[k], e_done);
         chk({tag, "_err"}, err[k], e_err);
         chk({tag, "_halt"}, halt[k], e_halt);
         chk({tag, "_core_rst_cycles"}, rst_cyc[k], e_rst);
         done_cnt[k] = 0;
         rst_cyc[k]  = 0;
      end
      chk({tag, "_sb0_left"}, sb0.size(), 0);
      chk({tag, "_sb1_left"}, sb1.size(), 0);
   endtask

   task automatic chk_all_zero(input string tag);
      for (int k = 0; k < 2; k++)
         chk(tag, {rx_ready[k], address[k], data_out[k], data_oe[k], ram_en[k], ram_rw[k],
                   halt[k], core_rst[k], busy[k], done[k], err[k]}, 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      repeat (3) @(negedge clk);
      chk_all_zero("reset_outputs");
      rst = 1'b0;
      @(negedge clk);

      // Good load.
      pulse_start();
      chk("start_halt", halt, 2'b11);
      chk("start_rx_ready", rx_ready, 2'b11);
      chk("start_busy", busy, 2'b11);
      exp_write(16'd0, 16'h1234);
      exp_write(16'd1, 16'hABCD);
      txq = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
      send_q();
      end_frame("good", 1, 1'b0, 1'b0, RSTC);

      // Bad checksum: writes still happen, then ERROR with core frozen.
      pulse_start();
      exp_write(16'd0, 16'h1234);
      exp_write(16'd1, 16'hABCD);
      txq = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
      send_q();
      end_frame("badcsum", 0, 1'b1, 1'b1, 0);
      chk("badcsum_busy", busy, 2'b00);
      pulse_start();
      chk("restart_err_clear", err, 2'b00);
      chk("restart_busy", busy, 2'b11);

      // Sync hunt then zero length.
      txq = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00};
      send_q();
      end_frame("zerolen", 0, 1'b1, 1'b1, 0);

      // Address wrap at the 0xFFFF instance.
      pulse_start();
      exp_write(16'd0, 16'h0001);
      exp_write(16'd1, 16'h0002);
      txq = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'h01};
      send_q();
      end_frame("wrap", 1, 1'b0, 1'b0, RSTC);

      // Timeout: stall after LEN_HI.
      pulse_start();
      txq = '{8'hA5, 8'h00};
      send_q();
      repeat (45) @(negedge clk);
      chk("tmo_not_yet_err", err, 2'b00);
      chk("tmo_not_yet_ready", rx_ready, 2'b11);
      repeat (15) @(negedge clk);
      chk("tmo_err", err, 2'b11);
      chk("tmo_halt", halt, 2'b11);
      chk("tmo_ready_low", rx_ready, 2'b00);

      // Reset mid-frame after the first write.
      pulse_start();
      exp_write(16'd0, 16'h1234);
      txq = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34};
      send_q();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_all_zero("midreset_outputs");
      end_frame("midreset", 0, 1'b0, 1'b0, 0);

      // Fresh good load after reset.
      pulse_start();
      exp_write(16'd0, 16'h1234);
      exp_write(16'd1, 16'hABCD);
      txq = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
      send_q();
      end_frame("reload", 1, 1'b0, 1'b0, RSTC);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
